// File: rtl/sop_pkg.sv
// Shared definitions for the minterm engine: sweep FSM encoding, table width helper
// and the power-on truth table of the original 4-input function.
package sop_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SCAN = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // f = m(4,8,9,12,13,14) for the 4-input build
    localparam logic [15:0] DEFAULT_TT = 16'h7310;

    function automatic int tt_w(input int n);
        return 1 << n;
    endfunction

endpackage

// File: rtl/sop_eval.sv
// Registered truth-table lookup: one result per accepted input vector, one cycle later.
// f holds its last value between evaluations.
module sop_eval #(
    parameter int N = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [sop_pkg::tt_w(N)-1:0]  tt_i,
    input  logic                         in_valid_i,
    input  logic [N-1:0]                 in_vec_i,
    output logic                         out_valid_o,
    output logic                         f_o
);

    logic out_valid_q;
    logic f_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            f_q         <= 1'b0;
        end else begin
            out_valid_q <= in_valid_i;
            if (in_valid_i) begin
                f_q <= tt_i[in_vec_i];
            end
        end
    end

    assign out_valid_o = out_valid_q;
    assign f_o         = f_q;

endmodule

// File: rtl/sop_minterm_engine.sv
// Runtime-loadable N-input truth table with registered evaluation and a minterm
// sweep that streams set indices over valid/ready and counts them.
module sop_minterm_engine #(
    parameter int                               N          = 4,
    parameter logic [sop_pkg::tt_w(N)-1:0]      DEFAULT_TT = sop_pkg::DEFAULT_TT
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         tt_load,
    input  logic [sop_pkg::tt_w(N)-1:0]  tt_data,
    input  logic                         in_valid,
    input  logic [N-1:0]                 in_vec,
    output logic                         out_valid,
    output logic                         f,
    input  logic                         scan_start,
    output logic                         scan_busy,
    output logic                         m_valid,
    input  logic                         m_ready,
    output logic [N-1:0]                 m_index,
    output logic                         m_last,
    output logic                         scan_done,
    output logic [N:0]                   ones_count
);
    import sop_pkg::*;

    localparam int           TT_W    = tt_w(N);
    localparam logic [N-1:0] IDX_MAX = {N{1'b1}};

    logic [TT_W-1:0] tt_q, tt_d;
    logic [1:0]      state_q, state_d;
    logic [N-1:0]    idx_q, idx_d;
    logic [N:0]      ones_q, ones_d;

    logic       cur_bit;
    logic [N:0] next_pos;

    assign cur_bit  = tt_q[idx_q];
    assign next_pos = {1'b0, idx_q} + (N+1)'(1);
    assign m_valid  = (state_q == ST_SCAN) && cur_bit;
    // Last beat: no set minterm above the current index (shift by 2^N yields zero)
    assign m_last   = m_valid && ((tt_q >> next_pos) == '0);

    always_comb begin
        state_d = state_q;
        tt_d    = tt_q;
        idx_d   = idx_q;
        ones_d  = ones_q;
        case (state_q)
            ST_IDLE: begin
                if (tt_load) begin
                    tt_d = tt_data;
                end
                if (scan_start) begin
                    state_d = ST_SCAN;
                    idx_d   = '0;
                    ones_d  = '0;
                end
            end
            ST_SCAN: begin
                if (m_valid && m_ready) begin
                    ones_d = ones_q + (N+1)'(1);
                end
                // Clear entries are skipped; set entries wait for the consumer
                if (!cur_bit || m_ready) begin
                    if (idx_q == IDX_MAX) begin
                        state_d = ST_DONE;
                    end else begin
                        idx_d = idx_q + N'(1);
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            tt_q    <= DEFAULT_TT;
            idx_q   <= '0;
            ones_q  <= '0;
        end else begin
            state_q <= state_d;
            tt_q    <= tt_d;
            idx_q   <= idx_d;
            ones_q  <= ones_d;
        end
    end

    sop_eval #(.N(N)) u_eval (
        .clk         (clk),
        .rst_n       (rst_n),
        .tt_i        (tt_q),
        .in_valid_i  (in_valid),
        .in_vec_i    (in_vec),
        .out_valid_o (out_valid),
        .f_o         (f)
    );

    assign scan_busy  = (state_q != ST_IDLE);
    assign scan_done  = (state_q == ST_DONE);
    assign m_index    = idx_q;
    assign ones_count = ones_q;

endmodule

// File: tb/tb_sop_minterm_engine.sv
// Bench for sop_minterm_engine: a cycle-level behavioural model checked every cycle,
// plus directed scenarios with hand-computed beat lists and cycle counts.
module tb_sop_minterm_engine;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        tt_load = 1'b0;
    logic [15:0] tt_data = '0;
    logic        in_valid = 1'b0;
    logic [3:0]  in_vec = '0;
    logic        out_valid, f;
    logic        scan_start = 1'b0;
    logic        scan_busy, m_valid, m_last, scan_done;
    logic        m_ready = 1'b1;
    logic [3:0]  m_index;
    logic [4:0]  ones_count;

    // Second build: N=3 with its own table
    logic        scanStart3 = 1'b0;
    logic        mReady3 = 1'b1;
    logic        outValid3, f3, scanBusy3, mValid3, mLast3, scanDone3;
    logic [2:0]  mIndex3;
    logic [3:0]  onesCount3;

    int errors = 0;
    int checks = 0;

    int beats[$];
    bit lasts[$];
    int beats3[$];

    always #5 clk = ~clk;

    sop_minterm_engine #(.N(4)) dut (
        .clk(clk), .rst_n(rst_n), .tt_load(tt_load), .tt_data(tt_data),
        .in_valid(in_valid), .in_vec(in_vec), .out_valid(out_valid), .f(f),
        .scan_start(scan_start), .scan_busy(scan_busy), .m_valid(m_valid),
        .m_ready(m_ready), .m_index(m_index), .m_last(m_last),
        .scan_done(scan_done), .ones_count(ones_count)
    );

    sop_minterm_engine #(.N(3), .DEFAULT_TT(8'h96)) dut3 (
        .clk(clk), .rst_n(rst_n), .tt_load(1'b0), .tt_data(8'h00),
        .in_valid(1'b0), .in_vec(3'd0), .out_valid(outValid3), .f(f3),
        .scan_start(scanStart3), .scan_busy(scanBusy3), .m_valid(mValid3),
        .m_ready(mReady3), .m_index(mIndex3), .m_last(mLast3),
        .scan_done(scanDone3), .ones_count(onesCount3)
    );

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: table, eval result, sweep position and count, stepped per clock
    logic [15:0] mTt = 16'h7310;
    bit          mOutValid = 0, mF = 0, mScan = 0, mDone = 0;
    int          mPos = 0, mOnes = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mTt = 16'h7310; mOutValid = 0; mF = 0;
            mScan = 0; mDone = 0; mPos = 0; mOnes = 0;
        end else begin
            mOutValid = in_valid;
            if (in_valid) mF = mTt[in_vec];
            if (mDone) begin
                mDone = 0;
            end else if (mScan) begin
                if (mTt[mPos] && m_ready) mOnes++;
                if (!mTt[mPos] || m_ready) begin
                    if (mPos == 15) begin
                        mScan = 0;
                        mDone = 1;
                    end else begin
                        mPos++;
                    end
                end
            end else begin
                if (tt_load) mTt = tt_data;
                if (scan_start) begin
                    mScan = 1; mPos = 0; mOnes = 0;
                end
            end
        end
    end

    // Compare every cycle on the falling edge, and log accepted beats
    bit stallPrev = 0;
    int stallIdx = 0;
    always @(negedge clk) begin
        if (rst_n) begin
            bit expMv;
            expMv = mScan && mTt[mPos];
            checkOutput("out_valid", out_valid, mOutValid);
            checkOutput("f", f, mF);
            checkOutput("scan_busy", scan_busy, mScan || mDone);
            checkOutput("scan_done", scan_done, mDone);
            checkOutput("m_valid", m_valid, expMv);
            if (expMv) begin
                checkOutput("m_index", m_index, mPos);
                checkOutput("m_last", m_last, (mTt >> (mPos + 1)) == 16'h0);
            end
            checkOutput("ones_count", ones_count, mOnes);
            if (stallPrev) begin
                checkOutput("stall_m_valid", m_valid, 1);
                checkOutput("stall_m_index", m_index, stallIdx);
            end
            stallPrev = m_valid && !m_ready;
            stallIdx  = m_index;
            if (m_valid && m_ready) begin
                beats.push_back(m_index);
                lasts.push_back(m_last);
            end
            if (mValid3 && mReady3) beats3.push_back(mIndex3);
        end else begin
            stallPrev = 0;
        end
    end

    task automatic applyStimulus(input logic ld, input logic [15:0] data, input logic iv,
                                 input logic [3:0] vec, input logic ss);
        tt_load = ld; tt_data = data; in_valid = iv; in_vec = vec; scan_start = ss;
        @(posedge clk); #1;
        tt_load = 1'b0; in_valid = 1'b0; scan_start = 1'b0;
    endtask

    // cycles counts the scan_start cycle as cycle 1
    task automatic runScan(input bit rnd, input bit ldDuring, input bit ldAtStart,
                           input logic [15:0] ldData, output int cycles);
        beats.delete(); lasts.delete();
        m_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        applyStimulus(ldAtStart, ldData, 1'b0, 4'd0, 1'b1);
        cycles = 1;
        while (!scan_done && cycles < 200) begin
            if (rnd) m_ready = 1'($urandom_range(0, 1));
            if (ldDuring) begin
                tt_load = 1'b1; tt_data = 16'hFFFF;
            end
            @(posedge clk); #1;
            cycles++;
        end
        tt_load = 1'b0;
        checkOutput("scan_done_seen", scan_done, 1);
        m_ready = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic checkBeats(input string name, input int expQ[$]);
        int lastCount = 0;
        checkOutput({name, "_count"}, beats.size(), expQ.size());
        foreach (expQ[i]) if (i < beats.size()) checkOutput({name, "_beat"}, beats[i], expQ[i]);
        foreach (lasts[i]) if (lasts[i]) lastCount++;
        checkOutput({name, "_lastCount"}, lastCount, (expQ.size() > 0) ? 1 : 0);
        if (lasts.size() > 0) checkOutput({name, "_lastOnFinal"}, lasts[lasts.size() - 1], 1);
    endtask

    task automatic checkResetOutputs(input string name);
        checkOutput({name, "_f"}, f, 0);
        checkOutput({name, "_out_valid"}, out_valid, 0);
        checkOutput({name, "_m_valid"}, m_valid, 0);
        checkOutput({name, "_m_last"}, m_last, 0);
        checkOutput({name, "_m_index"}, m_index, 0);
        checkOutput({name, "_scan_done"}, scan_done, 0);
        checkOutput({name, "_scan_busy"}, scan_busy, 0);
        checkOutput({name, "_ones_count"}, ones_count, 0);
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int cycles;
        int expQ[$];
        int c;
        logic [15:0] dflt;
        logic [3:0] onesVecs[6];
        dflt = 16'h7310;
        onesVecs = '{4'd4, 4'd8, 4'd9, 4'd12, 4'd13, 4'd14};

        rst_n = 1'b0;
        #12;
        checkResetOutputs("reset");
        @(posedge clk); #1;
        rst_n = 1'b1;

        $display("[TB] eval of default table");
        foreach (onesVecs[i]) begin
            applyStimulus(1'b0, 16'h0, 1'b1, onesVecs[i], 1'b0);
            checkOutput("eval_one", f, 1);
            checkOutput("eval_one_valid", out_valid, 1);
        end
        applyStimulus(1'b0, 16'h0, 1'b1, 4'd0, 1'b0);
        checkOutput("eval_v0", f, 0);
        applyStimulus(1'b0, 16'h0, 1'b1, 4'd15, 1'b0);
        checkOutput("eval_v15", f, 0);
        for (int v = 0; v < 16; v++) begin
            applyStimulus(1'b0, 16'h0, 1'b1, 4'(v), 1'b0);
            checkOutput("eval_exhaustive", f, dflt[v]);
        end
        @(posedge clk); #1;
        checkOutput("out_valid_pulse", out_valid, 0);

        $display("[TB] sweep default table, ready held high");
        runScan(1'b0, 1'b0, 1'b0, 16'h0, cycles);
        expQ = {4, 8, 9, 12, 13, 14};
        checkBeats("dflt", expQ);
        checkOutput("dflt_cycles", cycles, 17);
        checkOutput("dflt_ones", ones_count, 6);

        $display("[TB] sweep default table, random ready");
        runScan(1'b1, 1'b0, 1'b0, 16'h0, cycles);
        checkBeats("rnd", expQ);
        checkOutput("rnd_ones", ones_count, 6);

        $display("[TB] empty and full tables");
        applyStimulus(1'b1, 16'h0000, 1'b0, 4'd0, 1'b0);
        runScan(1'b0, 1'b0, 1'b0, 16'h0, cycles);
        expQ = {};
        checkBeats("empty", expQ);
        checkOutput("empty_cycles", cycles, 17);
        checkOutput("empty_ones", ones_count, 0);
        applyStimulus(1'b1, 16'hFFFF, 1'b0, 4'd0, 1'b0);
        runScan(1'b0, 1'b0, 1'b0, 16'h0, cycles);
        expQ = {};
        for (int i = 0; i < 16; i++) expQ.push_back(i);
        checkBeats("full", expQ);
        checkOutput("full_cycles", cycles, 17);
        checkOutput("full_ones", ones_count, 16);

        $display("[TB] load interactions");
        applyStimulus(1'b1, 16'h7310, 1'b0, 4'd0, 1'b0);
        applyStimulus(1'b1, 16'h0000, 1'b1, 4'd4, 1'b0);
        checkOutput("load_same_cycle_old_table", f, 1);
        applyStimulus(1'b0, 16'h0, 1'b1, 4'd4, 1'b0);
        checkOutput("load_new_table", f, 0);
        applyStimulus(1'b1, 16'h7310, 1'b0, 4'd0, 1'b0);
        runScan(1'b0, 1'b1, 1'b0, 16'h0, cycles);
        expQ = {4, 8, 9, 12, 13, 14};
        checkBeats("load_in_scan", expQ);
        runScan(1'b0, 1'b0, 1'b1, 16'h0003, cycles);
        expQ = {0, 1};
        checkBeats("load_with_start", expQ);
        checkOutput("load_with_start_ones", ones_count, 2);

        $display("[TB] reset in the middle of a sweep");
        applyStimulus(1'b1, 16'h7311, 1'b0, 4'd0, 1'b0);
        beats.delete(); lasts.delete();
        m_ready = 1'b1;
        applyStimulus(1'b0, 16'h0, 1'b0, 4'd0, 1'b1);
        c = 0;
        while (!(m_valid && m_index == 4'd9) && c < 40) begin
            @(posedge clk); #1;
            c++;
        end
        checkOutput("reached_beat9", m_index, 9);
        #2 rst_n = 1'b0;
        #1;
        checkResetOutputs("midscan_reset");
        expQ = {0, 4, 8};
        checkOutput("partial_count", beats.size(), 3);
        foreach (expQ[i]) if (i < beats.size()) checkOutput("partial_beat", beats[i], expQ[i]);
        @(posedge clk); #1;
        checkOutput("reset_held_done", scan_done, 0);
        rst_n = 1'b1;
        applyStimulus(1'b0, 16'h0, 1'b1, 4'd0, 1'b0);
        checkOutput("reset_table_restored", f, 0);
        runScan(1'b0, 1'b0, 1'b0, 16'h0, cycles);
        expQ = {4, 8, 9, 12, 13, 14};
        checkBeats("after_reset", expQ);

        $display("[TB] N=3 build");
        beats3.delete();
        scanStart3 = 1'b1;
        @(posedge clk); #1;
        scanStart3 = 1'b0;
        c = 0;
        while (!scanDone3 && c < 40) begin
            @(posedge clk); #1;
            c++;
        end
        checkOutput("n3_done_seen", scanDone3, 1);
        expQ = {1, 2, 4, 7};
        checkOutput("n3_count", beats3.size(), 4);
        foreach (expQ[i]) if (i < beats3.size()) checkOutput("n3_beat", beats3[i], expQ[i]);
        checkOutput("n3_ones", onesCount3, 4);

        repeat (2) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
